// File: rtl/alu_exec_stage.sv
// Execute slice of the 16-bit multicycle datapath: operand registers A/B, source muxes, ALU, ALUOut.
// Optional macro ALU_FLAGS_EN adds combinational Neg and Carry flag outputs.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int PCW   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic             AWrite,
  input  logic             BWrite,
  input  logic [PCW-1:0]   PC,
  input  logic [PCW-1:0]   OldPC,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             Neg,
  output logic             Carry
`endif
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_NOT   = 3'b100,
    OP_PASSB = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSA = 3'b111
  } alu_op_t;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  alu_op_t          op;

  assign op = alu_op_t'(ALUControl);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      A      <= '0;
      B      <= '0;
      ALUOut <= '0;
    end else begin
      if (AWrite) A <= RD1;
      if (BWrite) B <= RD2;
      ALUOut <= ALUResult;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      2'b00:   src_a = {{(WIDTH-PCW){1'b0}}, PC};
      2'b01:   src_a = {{(WIDTH-PCW){1'b0}}, OldPC};
      2'b10:   src_a = A;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (ALUSrcB)
      2'b00:   src_b = B;
      2'b01:   src_b = WIDTH'(1);
      2'b10:   src_b = ImmExt;
      default: src_b = '0;
    endcase
  end

  always_comb begin
    ALUResult = '0;
    case (op)
      OP_ADD:   ALUResult = src_a + src_b;
      OP_SUB:   ALUResult = src_a - src_b;
      OP_AND:   ALUResult = src_a & src_b;
      OP_OR:    ALUResult = src_a | src_b;
      OP_NOT:   ALUResult = ~src_b;
      OP_PASSB: ALUResult = src_b;
      OP_XOR:   ALUResult = src_a ^ src_b;
      OP_PASSA: ALUResult = src_a;
      default:  ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_wide;
  logic [WIDTH:0] sub_wide;

  // Subtraction as A + ~B + 1, so the top bit is the inverted borrow.
  assign add_wide = {1'b0, src_a} + {1'b0, src_b};
  assign sub_wide = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);

  assign Neg = ALUResult[WIDTH-1];

  always_comb begin
    Carry = 1'b0;
    case (op)
      OP_ADD:  Carry = add_wide[WIDTH];
      OP_SUB:  Carry = sub_wide[WIDTH];
      default: Carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, corner sequences, random vs. reference model.
// Flag outputs are checked when ALU_FLAGS_EN is defined.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic [15:0] RD1, RD2, ImmExt;
  logic        AWrite, BWrite;
  logic [11:0] PC, OldPC;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl;
  logic [15:0] A, B, ALUResult, ALUOut;
  logic        Zero;
`ifdef ALU_FLAGS_EN
  logic        Neg, Carry;
`endif

  int total = 0;
  int bad   = 0;

  alu_exec_stage #(.WIDTH(16), .PCW(12)) dut (
    .clk(clk), .reset(reset), .RD1(RD1), .RD2(RD2), .AWrite(AWrite), .BWrite(BWrite),
    .PC(PC), .OldPC(OldPC), .ImmExt(ImmExt), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .A(A), .B(B), .ALUResult(ALUResult), .ALUOut(ALUOut),
    .Zero(Zero)
`ifdef ALU_FLAGS_EN
    , .Neg(Neg), .Carry(Carry)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: operand values as integers, result reduced modulo 2^16.
  function automatic int src_a_val(input int sel, input int pc, input int oldpc, input int a);
    case (sel)
      0: return pc;
      1: return oldpc;
      2: return a;
      default: return 0;
    endcase
  endfunction

  function automatic int src_b_val(input int sel, input int b, input int imm);
    case (sel)
      0: return b;
      1: return 1;
      2: return imm;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_alu(input int op, input int x, input int y);
    case (op)
      0: return (x + y) % 65536;
      1: return (x - y + 65536) % 65536;
      2: return x & y;
      3: return x | y;
      4: return 65535 - y;
      5: return y;
      6: return x ^ y;
      default: return x;
    endcase
  endfunction

  function automatic int ref_carry(input int op, input int x, input int y);
    if (op == 0) return (x + y >= 65536) ? 1 : 0;
    if (op == 1) return (x >= y) ? 1 : 0;
    return 0;
  endfunction

  typedef struct {
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  op;
    logic [11:0] pc;
    logic [11:0] oldpc;
    logic [15:0] imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
    RD1 = a; RD2 = b; AWrite = 1'b1; BWrite = 1'b1;
    tick();
    AWrite = 1'b0; BWrite = 1'b0;
  endtask

  int ma, mb, mout, xa, xb, res;

  initial begin
    vecs[0]  = '{2'b00, 2'b01, 3'b000, 12'h07F, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'h0080};
    vecs[1]  = '{2'b10, 2'b00, 3'b001, 12'h000, 12'h000, 16'h0000, 16'h0007, 16'h0007, 16'h0000};
    vecs[2]  = '{2'b10, 2'b00, 3'b000, 12'h000, 12'h000, 16'h0000, 16'h0007, 16'h0007, 16'h000E};
    vecs[3]  = '{2'b10, 2'b01, 3'b000, 12'h000, 12'h000, 16'h0000, 16'hFFFF, 16'h0007, 16'h0000};
    vecs[4]  = '{2'b10, 2'b00, 3'b010, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'h00F0};
    vecs[5]  = '{2'b10, 2'b00, 3'b011, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'hFFF0};
    vecs[6]  = '{2'b10, 2'b00, 3'b110, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'hFF00};
    vecs[7]  = '{2'b10, 2'b00, 3'b100, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'hF00F};
    vecs[8]  = '{2'b10, 2'b00, 3'b101, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'h0FF0};
    vecs[9]  = '{2'b10, 2'b00, 3'b111, 12'h000, 12'h000, 16'h0000, 16'hF0F0, 16'h0FF0, 16'hF0F0};
    vecs[10] = '{2'b01, 2'b10, 3'b000, 12'h000, 12'h123, 16'h0010, 16'h0000, 16'h0000, 16'h0133};
    vecs[11] = '{2'b11, 2'b01, 3'b001, 12'h000, 12'h000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[12] = '{2'b11, 2'b11, 3'b011, 12'hFFF, 12'hFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[13] = '{2'b10, 2'b10, 3'b000, 12'h000, 12'h000, 16'h8000, 16'h8000, 16'h0000, 16'h0000};

    // Reset asserted from time zero while A is enabled: everything reads zero before any edge.
    reset = 1'b0; AWrite = 1'b1; BWrite = 1'b0; RD1 = 16'h1234; RD2 = 16'h0000;
    PC = '0; OldPC = '0; ImmExt = '0; ALUSrcA = 2'b11; ALUSrcB = 2'b11; ALUControl = 3'b000;
    #2;
    check("reset_a", A, 16'h0000);
    check("reset_b", B, 16'h0000);
    check("reset_aluout", ALUOut, 16'h0000);
    tick();
    check("reset_hold_a", A, 16'h0000);
    #2 reset = 1'b1;
    #1 check("release_no_edge_a", A, 16'h0000);
    tick();
    check("load_a", A, 16'h1234);

    AWrite = 1'b0; RD1 = 16'hBEEF;
    repeat (3) tick();
    check("hold_a", A, 16'h1234);
    check("hold_b", B, 16'h0000);
    BWrite = 1'b1; RD2 = 16'h0005;
    tick();
    BWrite = 1'b0;
    check("load_b", B, 16'h0005);
    check("load_b_keeps_a", A, 16'h1234);

    for (int i = 0; i < 14; i++) begin
      load_ab(vecs[i].a, vecs[i].b);
      ALUSrcA = vecs[i].sa; ALUSrcB = vecs[i].sb; ALUControl = vecs[i].op;
      PC = vecs[i].pc; OldPC = vecs[i].oldpc; ImmExt = vecs[i].imm;
      #1;
      check($sformatf("vec%0d_result", i), ALUResult, vecs[i].exp);
      check($sformatf("vec%0d_zero", i), {15'd0, Zero}, {15'd0, vecs[i].exp == 16'h0000});
`ifdef ALU_FLAGS_EN
      xa = src_a_val(int'(vecs[i].sa), int'(vecs[i].pc), int'(vecs[i].oldpc), int'(vecs[i].a));
      xb = src_b_val(int'(vecs[i].sb), int'(vecs[i].b), int'(vecs[i].imm));
      check($sformatf("vec%0d_neg", i), {15'd0, Neg}, {15'd0, vecs[i].exp[15]});
      check($sformatf("vec%0d_carry", i), {15'd0, Carry},
            16'(ref_carry(int'(vecs[i].op), xa, xb)));
`endif
      tick();
      check($sformatf("vec%0d_aluout", i), ALUOut, vecs[i].exp);
    end

    // Randomized run against the integer reference model.
    load_ab(16'(($urandom)), 16'(($urandom)));
    ma = int'(A); mb = int'(B);
    for (int i = 0; i < 300; i++) begin
      RD1 = 16'($urandom); RD2 = 16'($urandom);
      AWrite = 1'($urandom); BWrite = 1'($urandom);
      PC = 12'($urandom); OldPC = 12'($urandom); ImmExt = 16'($urandom);
      ALUSrcA = 2'($urandom); ALUSrcB = 2'($urandom); ALUControl = 3'($urandom);
      #1;
      xa = src_a_val(int'(ALUSrcA), int'(PC), int'(OldPC), ma);
      xb = src_b_val(int'(ALUSrcB), mb, int'(ImmExt));
      res = ref_alu(int'(ALUControl), xa, xb);
      check($sformatf("rnd%0d_result", i), ALUResult, 16'(res));
      check($sformatf("rnd%0d_zero", i), {15'd0, Zero}, {15'd0, res == 0});
`ifdef ALU_FLAGS_EN
      check($sformatf("rnd%0d_carry", i), {15'd0, Carry}, 16'(ref_carry(int'(ALUControl), xa, xb)));
      check($sformatf("rnd%0d_neg", i), {15'd0, Neg}, {15'd0, res >= 32768});
`endif
      tick();
      mout = res;
      if (AWrite) ma = int'(RD1);
      if (BWrite) mb = int'(RD2);
      check($sformatf("rnd%0d_a", i), A, 16'(ma));
      check($sformatf("rnd%0d_b", i), B, 16'(mb));
      check($sformatf("rnd%0d_aluout", i), ALUOut, 16'(mout));
    end

    // Reset asserted mid-sequence clears state at once; ALUResult follows the cleared A/B.
    AWrite = 1'b0; BWrite = 1'b0;
    load_ab(16'h5A5A, 16'hA5A5);
    ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUControl = 3'b011;
    tick();
    check("pre_reset_aluout", ALUOut, 16'hFFFF);
    #2 reset = 1'b0;
    #1;
    check("midreset_a", A, 16'h0000);
    check("midreset_b", B, 16'h0000);
    check("midreset_aluout", ALUOut, 16'h0000);
    check("midreset_result", ALUResult, 16'h0000);
    check("midreset_zero", {15'd0, Zero}, 16'h0001);
    tick();
    reset = 1'b1;
    RD1 = 16'h0042; AWrite = 1'b1;
    #1 check("post_release_a", A, 16'h0000);
    tick();
    check("post_release_load_a", A, 16'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute slice of the 16-bit multicycle datapath.
- Holds the operand registers A and B, each with its own write enable, and the ALU source-select muxes.
- Contains a combinational ALU with a Zero flag and the free-running ALUOut register.
- Sits between the register file (RD1/RD2) and the result mux and PC-next logic.

Parameters:
- WIDTH, 16, data path width of the operand registers, ALU and ALUOut.
- PCW, 12, program-counter width; PC and OldPC are zero-extended to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- RD1  in  WIDTH  register-file read port 1 (accumulator R0).
- RD2  in  WIDTH  register-file read port 2.
- AWrite  in  1  load enable for register A.
- BWrite  in  1  load enable for register B.
- PC  in  PCW  current PC.
- OldPC  in  PCW  PC of the current instruction.
- ImmExt  in  WIDTH  extended immediate.
- ALUSrcA  in  2  SrcA select.
- ALUSrcB  in  2  SrcB select.
- ALUControl  in  3  operation select.
- A  out  WIDTH  register A.
- B  out  WIDTH  register B.
- ALUResult  out  WIDTH  combinational ALU result.
- ALUOut  out  WIDTH  registered ALU result.
- Zero  out  1  combinational; 1 when ALUResult == 0.

Behaviour:
- Reset: while reset = 0, A, B and ALUOut are 0 immediately, independent of clk. Reset has priority over all enables.
- Register A: on posedge clk, A <= RD1 if AWrite = 1, otherwise holds. Same rule for B with RD2 and BWrite. Both enables may be high together; both registers load.
- SrcA select:
  - 00 = {zeros, PC}
  - 01 = {zeros, OldPC}
  - 10 = A
  - 11 = 0
- SrcB select:
  - 00 = B
  - 01 = constant 1
  - 10 = ImmExt
  - 11 = 0
- ALU operations (fully combinational, WIDTH bits, modulo 2^WIDTH, carry discarded):
  - 000 ADD: SrcA + SrcB
  - 001 SUB: SrcA - SrcB (two's complement)
  - 010 AND
  - 011 OR
  - 100 NOT: ~SrcB
  - 101 PASSB: SrcB
  - 110 XOR
  - 111 PASSA: SrcA
- Zero is combinational from ALUResult and is valid in the same cycle.
- ALUOut has no enable: on every posedge clk, ALUOut <= ALUResult, giving 1-cycle latency.
- A and B feed the muxes as registered values. A value loaded into A at edge N affects ALUResult after edge N and reaches ALUOut at edge N+1.
- Wrap-around: 16'hFFFF + 1 = 16'h0000 with Zero = 1. 16'h0000 - 1 = 16'hFFFF.
- Reset released between edges: registers stay 0 until the next posedge. Reset asserted mid-sequence clears A, B and ALUOut at once; ALUResult follows the mux inputs with no state.
- No X is ever propagated for valid select codes. Reserved select code 11 yields 0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, the block adds two output ports:
  - Neg (1 bit) = ALUResult[WIDTH-1].
  - Carry (1 bit) = carry-out for ADD, NOT-borrow for SUB, 0 for all other ops.
- Both are combinational and not registered.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: drive reset = 0 with AWrite = 1 and RD1 = 16'h1234 -> A = B = ALUOut = 0 with no clock edge. Release reset, clock once -> A = 16'h1234.
- Enable hold: AWrite = 0, RD1 = 16'hBEEF, clock 3 times -> A is unchanged. BWrite = 1 with RD2 = 16'h0005, clock -> B = 16'h0005.
- PC increment: ALUSrcA = 00, PC = 12'h07F, ALUSrcB = 01, ALUControl = 000 -> ALUResult = 16'h0080 immediately; ALUOut = 16'h0080 after the next edge.
- Arithmetic and Zero: A = 16'h0007, B = 16'h0007, ALUSrcA = 10, ALUSrcB = 00.
  - SUB -> ALUResult = 0, Zero = 1.
  - ADD -> 16'h000E, Zero = 0.
  - A = 16'hFFFF, SrcB = 1, ADD -> 0, Zero = 1.
- Logic ops: A = 16'hF0F0, B = 16'h0FF0.
  - AND -> 16'h00F0
  - OR -> 16'hFFF0
  - XOR -> 16'hFF00
  - NOT -> 16'hF00F
  - PASSB -> 16'h0FF0
  - PASSA -> 16'hF0F0
- Branch/immediate path: ALUSrcA = 01, OldPC = 12'h123, ALUSrcB = 10, ImmExt = 16'h0010, ADD -> 16'h0133. With ALU_FLAGS_EN defined, 16'h8000 + 16'h8000 -> Carry = 1, Neg = 0, Zero = 1.
